gemm_stream_ctrl: RTL
=====================

// Module: gemm_stream_ctrl
// PURPOSE
//  Byte-stream front/back end for the 2x2 GEMM core (Cout = alpha*A*B + beta*C*D, 8-bit elements).
//  - Accepts a framed operand stream and packs it into the core's 32-bit A/B/C/D words.
//  - Waits out the core latency, captures gemm_cout, then streams the 4 result bytes back out.
//  - Sits between the host byte interface and the gemm instance; the core is instantiated outside.
// PARAMETERS
//  GEMM_LAT  1   core clock cycles from stable operands to valid gemm_cout (>=1)
//  CNT_W     16  width of the completed-operation counter op_count
// PORTS
//  clk        in   1   single clock, all logic on posedge
//  rst_n      in   1   asynchronous, active-low reset
//  s_valid    in   1   operand byte valid
//  s_ready    out  1   operand byte accepted when s_valid & s_ready
//  s_data     in   8   operand byte
//  s_last     in   1   marks final byte of an operand frame
//  m_valid    out  1   result byte valid
//  m_ready    in   1   result byte consumed when m_valid & m_ready
//  m_data     out  8   result byte
//  m_last     out  1   marks 4th (final) result byte
//  gemm_a/b/c/d out 32 packed operands to core, {[0][0],[0][1],[1][0],[1][1]}, MSB byte = [0][0]
//  gemm_cout  in   32  core result, same packing
//  busy       out  1   high in any state other than LOAD
//  frame_err  out  1   one-cycle pulse on framing error
//  op_count   out  CNT_W  completed operations, wraps at 2^CNT_W
// BEHAVIOUR
//  Reset (async, rst_n=0): state=LOAD, byte_cnt=0, gemm_a..d=0, m_valid=0, m_data=0, m_last=0,
//   busy=0, frame_err=0, op_count=0, result reg=0. Partial frames discarded; s_ready=1 on release.
//  FSM: LOAD -> WAIT -> CAPTURE -> SEND -> LOAD.
//  LOAD: s_ready=1. Frame = 16 bytes: A,B,C,D, each MSB-first ([0][0] first). Byte n shifts into
//   word n/4 at byte lane 3-(n%4); byte_cnt increments per handshake.
//   - Accepted byte 15 with s_last=1: -> WAIT, lat_cnt=GEMM_LAT.
//   - s_last=1 on byte <15, or s_last=0 on byte 15: frame_err pulses next cycle, byte_cnt=0,
//     gemm_a..d cleared to 0, stay LOAD, nothing issued, op_count unchanged.
//  WAIT: s_ready=0; operands held stable; lat_cnt decrements each cycle; at 1 -> CAPTURE.
//  CAPTURE: one cycle; result reg <= gemm_cout at end of cycle; -> SEND, m_valid=1, m_data=res[31:24].
//  SEND: bytes res[31:24],[23:16],[15:8],[7:0]; m_data/m_last stable while m_valid & !m_ready.
//   m_last=1 only with 4th byte. On 4th handshake: m_valid=0, op_count+1, byte_cnt=0 -> LOAD.
//  s_ready is combinational from state (LOAD only); s_valid outside LOAD is ignored, not lost upstream.
//  Arithmetic is the core's: 8-bit element results wrap mod 256; this block never alters data.
//  Latency: last operand handshake to m_valid rising = GEMM_LAT+1 cycles.
//  No overlap: next frame accepted only after final result byte handshake.
// CONFIGURATION
//  GEMM_IDENTITY_D_EN defined: frame is 12 bytes (A,B,C); s_last expected on byte 11;
//   gemm_d tied to identity 32'h01000001 (also its reset value). Core computes 2*A*B + C.
//  Not defined: 16-byte frame as above; gemm_d loaded from stream.
// TESTING
//  1 A=01020304,B=01000001,C=0,D=0 -> gemm_cout 02040608; out bytes 02,04,06,08, m_last on 08.
//  2 A=0,B=0,C=05060708,D=01000001 -> out 05,06,07,08; op_count increments 1 per frame.
//  3 Test 1 with m_ready low 5 cycles after m_valid -> m_data holds 02, s_ready stays 0, no loss.
//  4 s_last on byte 7 -> frame_err 1-cycle pulse, no m_valid, byte_cnt=0; next good frame = test 1 result.
//  5 rst_n low after 9 bytes (also mid-SEND) -> all outputs at reset values; fresh frame correct.
//  6 GEMM_IDENTITY_D_EN: A=01020304,B=01000001,C=01010101 (12 bytes) -> out 03,05,07,09.
//  7 A=80808080,B=01000001,C=0,D=0 -> out 00,00,00,00 (wrap passthrough).

Source files
------------

// File: rtl/gemm_stream_ctrl.sv
// gemm_stream_ctrl: packs a framed operand byte stream into the 2x2 GEMM core and streams its result back.
// GEMM_IDENTITY_D_EN: 12-byte A,B,C frame with gemm_d tied to the identity matrix.
module gemm_stream_ctrl #(
    parameter int GEMM_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [7:0]       s_data,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [7:0]       m_data,
    output logic             m_last,
    output logic [31:0]      gemm_a,
    output logic [31:0]      gemm_b,
    output logic [31:0]      gemm_c,
    output logic [31:0]      gemm_d,
    input  logic [31:0]      gemm_cout,
    output logic             busy,
    output logic             frame_err,
    output logic [CNT_W-1:0] op_count
);
`ifdef GEMM_IDENTITY_D_EN
    localparam int NW = 3;
`else
    localparam int NW = 4;
`endif
    localparam logic [3:0] LAST = 4'(4 * NW - 1);
    localparam int LW = $clog2(GEMM_LAT + 1);
    typedef enum logic [1:0] {LOAD, WAIT, CAPTURE, SEND} state_t;
    state_t state, state_nxt;
    logic [NW-1:0][31:0] ops;
    logic [3:0] byte_cnt;
    logic [LW-1:0] lat_cnt;
    logic [1:0] idx;
    logic [31:0] res;
    logic acc, done, err, hs;
    assign acc  = s_valid & s_ready;
    assign hs   = m_valid & m_ready;
    assign done = acc & s_last & (byte_cnt == LAST);
    assign err  = acc & (s_last != (byte_cnt == LAST));
    assign gemm_a = ops[0];
    assign gemm_b = ops[1];
    assign gemm_c = ops[2];
`ifdef GEMM_IDENTITY_D_EN
    assign gemm_d = 32'h0100_0001;
`else
    assign gemm_d = ops[3];
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LOAD;
        else        state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    state_nxt = done ? WAIT : LOAD;
            WAIT:    state_nxt = (lat_cnt == LW'(1)) ? CAPTURE : WAIT;
            CAPTURE: state_nxt = SEND;
            SEND:    state_nxt = (hs && idx == 2'd3) ? LOAD : SEND;
            default: state_nxt = LOAD;
        endcase
    end
    always_comb begin
        s_ready = state == LOAD;
        busy    = state != LOAD;
    end
    // Byte n lands in word n/4 at lane 3-(n%4), i.e. lane = ~n[1:0].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ops       <= '0;
            byte_cnt  <= '0;
            lat_cnt   <= '0;
            idx       <= '0;
            res       <= '0;
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_last    <= 1'b0;
            frame_err <= 1'b0;
            op_count  <= '0;
        end else begin
            frame_err <= err;
            if (acc) byte_cnt <= err ? 4'd0 : byte_cnt + 4'd1;
            if (err) ops <= '0;
            else if (acc) ops[byte_cnt[3:2]][{~byte_cnt[1:0], 3'b000} +: 8] <= s_data;
            if (done) lat_cnt <= LW'(GEMM_LAT);
            else if (state == WAIT) lat_cnt <= lat_cnt - LW'(1);
            if (state == CAPTURE) begin
                res     <= gemm_cout;
                m_valid <= 1'b1;
                m_data  <= gemm_cout[31:24];
                m_last  <= 1'b0;
                idx     <= 2'd0;
            end else if (hs) begin
                idx    <= idx + 2'd1;
                m_data <= idx == 2'd0 ? res[23:16] : idx == 2'd1 ? res[15:8] : res[7:0];
                m_last <= idx == 2'd2;
                if (idx == 2'd3) begin
                    m_valid  <= 1'b0;
                    m_last   <= 1'b0;
                    op_count <= op_count + CNT_W'(1);
                    byte_cnt <= 4'd0;
                end
            end
        end
    end
endmodule
